// File: rtl/spi_tx_queue_if.sv
// ============================================================================
// Module      : spi_tx_queue_if
// Description : CPU write port, serialiser load port and status bundle for
//               the SPI transmit queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_tx_queue_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  clr_overflow;
  logic                  tx_busy;
  logic                  tx_set_enable_n;
  logic [7:0]            tx_data;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  idle;

  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_busy,
    output tx_set_enable_n, tx_data, count, empty, full, overflow, idle
  );

  modport master (
    output wr_en, wr_data, clr_overflow, tx_busy,
    input  tx_set_enable_n, tx_data, count, empty, full, overflow, idle
  );
endinterface

`default_nettype wire

// File: rtl/spi_tx_queue.sv
// ============================================================================
// Module      : spi_tx_queue
// Description : Byte FIFO feeding the SPI serialiser one load at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx_queue #(
  parameter int DEPTH_LOG2    = 3,
  parameter int LOAD_CYCLES   = 2,
  parameter int START_TIMEOUT = 64
) (
  input  wire logic       set_clk,
  input  wire logic       reset,
  spi_tx_queue_if.slave   bus
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CTR_MAX = (START_TIMEOUT > LOAD_CYCLES) ? START_TIMEOUT : LOAD_CYCLES;
  localparam int CTR_W  = $clog2(CTR_MAX + 1);

  localparam logic [CTR_W-1:0]      c_load_last = CTR_W'(LOAD_CYCLES - 1);
  localparam logic [CTR_W-1:0]      c_to_last   = CTR_W'(START_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0]   c_depth     = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic                  overflow_q;
  logic                  busy_meta_q, busy_s_q;

  state_t                state_q, state_d;
  logic [CTR_W-1:0]      ctr_q,   ctr_d;
  logic                  sen_q,   sen_d;
  logic [7:0]            tx_data_q, tx_data_d;

  logic                  w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_depth);
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign w_push  = bus.wr_en && (!w_full || w_pop);
  assign w_drop  = bus.wr_en && w_full && !w_pop;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge set_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge set_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
      if (w_drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
      end
      busy_meta_q <= bus.tx_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  always_ff @(posedge set_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctr_q     <= '0;
      sen_q     <= 1'b1;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      sen_q     <= sen_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    sen_d     = sen_q;
    tx_data_d = tx_data_q;
    w_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          state_d   = ST_LOAD;
          w_pop     = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          sen_d     = 1'b0;
          ctr_d     = '0;
        end
      end
      ST_LOAD: begin
        if (ctr_q == c_load_last) begin
          sen_d   = 1'b1;
          state_d = ST_WAIT_START;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      ST_WAIT_START: begin
        // A serialiser that never reports busy must not stall the queue forever.
        if (busy_s_q) begin
          state_d = ST_WAIT_DONE;
        end else if (ctr_q == c_to_last) begin
          state_d = ST_GAP;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s_q) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sen_d   = 1'b1;
      end
    endcase
  end

  assign bus.tx_set_enable_n = sen_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.count           = count_q;
  assign bus.empty           = w_empty;
  assign bus.full            = w_full;
  assign bus.overflow        = overflow_q;
  assign bus.idle            = w_empty && (state_q == ST_IDLE);

endmodule

`default_nettype wire
